// File: rtl/led_pulse_pkg.sv
// Shared types for the LED/buzzer pulse driver; the state enum is also used
// by the reaction-timer top for debug muxing.
package led_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pulse_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/led_pulse_driver_sat_counter.sv
// Saturating up/down counter holding queued pulse requests; flags a dropped
// increment with a registered one-cycle overflow pulse.
module sat_up_down_counter #(
   parameter  int MAX = 7,
   localparam int W   = $clog2(MAX + 1)
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o,
   output logic         ovf_o
);

   logic [W-1:0] count_q, count_d;
   logic         ovf_q, ovf_d;

   // Next count: simultaneous inc and dec cancel; both ends saturate.
   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      if (clr_i) begin
         count_d = {W{1'b0}};
         ovf_d   = 1'b0;
      end else if (inc_i && !dec_i) begin
         if (count_q == W'(MAX)) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + W'(1);
         end
      end else if (dec_i && !inc_i) begin
         if (count_q != {W{1'b0}}) begin
            count_d = count_q - W'(1);
         end else begin
            count_d = count_q;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Count and overflow registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= {W{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/led_pulse_driver.sv
// Turns one-cycle request ticks into HIGH_CYCLES-wide pulses, each followed by
// a LOW_CYCLES guard gap; requests arriving mid-pulse are queued.
module led_pulse_driver
   import led_pulse_pkg::*;
#(
   parameter  int HIGH_CYCLES = 2000000,
   parameter  int LOW_CYCLES  = 2000000,
   parameter  int PENDING_MAX = 7,
   localparam int PW          = $clog2(PENDING_MAX + 1)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          tick_i,
   input  logic          clear_i,
   output logic          pulse_o,
   output logic          busy_o,
   output logic [PW-1:0] pending_o,
   output logic          overflow_o
);

   localparam int CW = $clog2(max_of(HIGH_CYCLES, LOW_CYCLES) + 1);

   pulse_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q;
   logic          inc_s, dec_s;
   logic [PW-1:0] pend_s;
   logic          ovf_s;
   logic          pend_nz_s;

   assign pend_nz_s = (pend_s != {PW{1'b0}});

   // Next state, timing counter and queue control for this cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inc_s   = 1'b0;
      dec_s   = 1'b0;
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = {CW{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               // The starting request is consumed directly, never queued.
               if (tick_i) begin
                  state_d = HIGH;
                  cnt_d   = {CW{1'b0}};
               end else begin
                  state_d = IDLE;
               end
            end
            HIGH: begin
               inc_s = tick_i;
               if (cnt_q == CW'(HIGH_CYCLES - 1)) begin
                  state_d = LOW;
                  cnt_d   = {CW{1'b0}};
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            LOW: begin
               inc_s = tick_i;
               if (cnt_q == CW'(LOW_CYCLES - 1)) begin
                  cnt_d = {CW{1'b0}};
                  if (pend_nz_s) begin
                     state_d = HIGH;
                     dec_s   = 1'b1;
                  end else if (tick_i) begin
                     // Back-to-back pulse from a tick on the last guard cycle.
                     state_d = HIGH;
                     inc_s   = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = {CW{1'b0}};
            end
         endcase
      end
   end

   // FSM, timing counter and registered pulse output.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= (state_d == HIGH);
      end
   end

   sat_up_down_counter #(
      .MAX (PENDING_MAX)
   ) u_pending (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (inc_s),
      .dec_i   (dec_s),
      .clr_i   (clear_i),
      .count_o (pend_s),
      .ovf_o   (ovf_s)
   );

   assign pulse_o    = pulse_q;
   assign busy_o     = (state_q != IDLE);
   assign pending_o  = pend_s;
   assign overflow_o = ovf_s;

endmodule
